uart_tx_ext: RTL and testbench
==============================

# uart_tx_ext

Parametrised UART transmitter with an input FIFO, runtime-selectable parity and stop-bit count, and oversampled bit timing driven by an external baud tick. It sits between the AHB UART register front end, which pushes bytes with a valid/ready handshake, and the serial `tx` pin. It replaces the fixed 8N1, single-byte transmitter in the AHB UART.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame; legal range 5..9, enforced by an elaboration-time check.
- `OVERSAMPLE`, 16, `b_tick` pulses per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4, input FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `b_tick`  in  1  one-cycle oversample tick from the baud generator.
- `d_in`  in  DATA_BITS  data word to transmit.
- `tx_valid`  in  1  `d_in` is valid.
- `tx_ready`  out  1  FIFO can accept a word; equals `!full`.
- `parity_mode`  in  2  00 = none, 01 = even, 10 = odd, 11 = none (reserved).
- `two_stop`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx`  out  1  serial line, registered; idles high.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's last stop bit.
- `busy`  out  1  high when the FSM is outside IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of FIFO entries occupied.

## Operation
- A push happens on any cycle with `tx_valid && tx_ready`. When the FIFO is full, `tx_ready` is 0 and the word is dropped. No push is accepted on a full FIFO, even if a pop occurs in the same cycle.
- The FSM has five states:
  - IDLE: `tx` = 1. When the FIFO is non-empty, pop, latch data, `parity_mode` and `two_stop`, then go to START.
  - START: `tx` = 0 for one bit, then go to DATA.
  - DATA: shift out `DATA_BITS` bits, LSB first. After the last bit, go to PARITY if a parity mode is active, else to STOP.
  - PARITY: even parity sends `^data`; odd parity sends `~^data`.
  - STOP: `tx` = 1 for one bit, or two bits if the latched `two_stop` is 1.
- A bit ends on a cycle where `b_tick` = 1 and the tick counter = OVERSAMPLE−1. On that cycle the tick counter wraps to 0.
- The tick counter and bit counter are cleared on every state entry. `b_tick` is ignored in IDLE.
- At the end of the final stop bit:
  - `tx_done` pulses.
  - If the FIFO is non-empty, pop in the same cycle and go directly to START, giving back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- Configuration inputs that change mid-frame have no effect until the next frame start.
- Frame length in `b_tick` pulses = OVERSAMPLE × (1 + DATA_BITS + P + S), where P = 1 if parity is active (else 0) and S = 1 or 2.

## Timing
- Reset values: `tx` = 1, `tx_done` = 0, `busy` = 0, `tx_ready` = 1, `fifo_level` = 0. FSM is in IDLE and counters are 0.
- Reset asserted mid-frame: `tx` is 1 on the next cycle, the FIFO is flushed, and no `tx_done` is generated.
- Push into an empty FIFO while IDLE:
  - cycle N: handshake;
  - cycle N+1: `fifo_level` = 1, and the pop occurs;
  - cycle N+2: `tx` = 0 and `busy` = 1.
- `fifo_level` updates on the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
- `tx_done` is high for exactly one cycle: the cycle the FSM leaves STOP.
- A `b_tick` coinciding with a frame start is not counted toward the start bit.

## Structure
- Shared package `uart_pkg` holds:
  - `parity_mode_e`: NONE, EVEN, ODD, RSVD;
  - `uart_tx_state_e`: IDLE, START, DATA, PARITY, STOP;
  - the legal `DATA_BITS` range constants.
- One sub-module, `uart_sync_fifo`:
  - parameters: width, depth;
  - ports: push, pop, full, empty, level;
  - the same one-clock, synchronous active-high reset.
- The FSM, the tick and bit counters, and the shift register live in `uart_tx_ext`.

## Test plan
- 8N1, OVERSAMPLE = 16, push 0xA5: `tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1. Each bit lasts exactly 16 ticks, the frame is 160 ticks, and `tx_done` pulses once.
- 8E2 with 0x5A: parity bit 0 and two stop bits, 192 ticks. The same word as 8O1 gives parity bit 1 and 176 ticks.
- Push 5 words back-to-back with FIFO_DEPTH = 4 while IDLE: the first 5 are accepted, since the first word leaves the FIFO at N+1. `tx_ready` drops when the FIFO is full. Frames are contiguous, with no high gap between the stop bit and the next start bit. `tx_done` pulses 5 times.
- `parity_mode` changed from EVEN to ODD mid-DATA: the current frame uses EVEN and the next frame uses ODD.
- `reset` asserted during DATA with 2 words queued: the next cycle shows `tx` = 1, `fifo_level` = 0 and `busy` = 0. No further frames are sent and no `tx_done` is seen.
- DATA_BITS = 5, parity none, push 0x13: 5 data bits 1,1,0,0,1, frame of 112 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: parity encodings, transmitter FSM states,
// legal data-width range and a parity helper.
package uart_pkg;

   localparam int unsigned DataBitsMin = 5;
   localparam int unsigned DataBitsMax = 9;

   typedef enum logic [1:0] {
      ParityNone = 2'b00,
      ParityEven = 2'b01,
      ParityOdd  = 2'b10,
      ParityRsvd = 2'b11
   } parity_mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_tx_state_e;

   // Zero-extended data does not change the XOR reduction.
   function automatic logic parity_bit(input parity_mode_e mode,
                                       input logic [DataBitsMax-1:0] data);
      return (mode == ParityOdd) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. Pushes into a full
// FIFO are dropped even when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
      $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q;
   logic [PtrW-1:0]  rptr_q;
   logic [LvlW-1:0]  level_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == LvlW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q];
   assign level   = level_q;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         if (do_push && !do_pop) begin
            level_q <= level_q + 1'b1;
         end else if (!do_push && do_pop) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter: input FIFO, runtime parity/stop-bit selection, oversampled
// bit timing from an external baud tick, back-to-back frames without idle gap.
module uart_tx_ext
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            b_tick,
   input  logic [DATA_BITS-1:0]            d_in,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   input  logic [1:0]                      parity_mode,
   input  logic                            two_stop,
   output logic                            tx,
   output logic                            tx_done,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = $clog2(DATA_BITS);
   localparam logic [TickW-1:0] TickMax = TickW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0]  BitMax  = BitW'(DATA_BITS - 1);

   if (DATA_BITS < DataBitsMin || DATA_BITS > DataBitsMax) begin : gen_bad_data_bits
      $error("uart_tx_ext: DATA_BITS out of range 5..9");
   end
   if (OVERSAMPLE < 2) begin : gen_bad_oversample
      $error("uart_tx_ext: OVERSAMPLE must be at least 2");
   end

   uart_tx_state_e       state_q;
   logic [TickW-1:0]     tick_q;
   logic [BitW-1:0]      bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_en_q;
   logic                 par_bit_q;
   logic                 two_stop_q;
   logic                 tx_q;
   logic                 done_q;

   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 bit_end;
   logic                 last_data;
   logic                 last_stop;
   parity_mode_e         mode;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_valid),
      .wdata (d_in),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Bit-boundary detection and FIFO pop decision.
   always_comb begin
      mode      = parity_mode_e'(parity_mode);
      bit_end   = b_tick && (tick_q == TickMax);
      last_data = (bit_q == BitMax);
      last_stop = (bit_q == BitW'(two_stop_q));
      fifo_pop  = !fifo_empty &&
                  ((state_q == StIdle) || (state_q == StStop && bit_end && last_stop));
   end

   // Frame sequencer with registered serial output and done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Tick counter wraps on every bit end, so it is zero on each state entry.
         if (state_q != StIdle && b_tick) begin
            tick_q <= bit_end ? '0 : tick_q + 1'b1;
         end
         // Every pop starts a frame: capture the word and its configuration.
         if (fifo_pop) begin
            shift_q    <= fifo_rdata;
            par_en_q   <= (mode == ParityEven) || (mode == ParityOdd);
            par_bit_q  <= parity_bit(mode, DataBitsMax'(fifo_rdata));
            two_stop_q <= two_stop;
         end
         unique case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (fifo_pop) begin
                  state_q <= StStart;
                  tx_q    <= 1'b0;
                  tick_q  <= '0;
                  bit_q   <= '0;
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_q <= StData;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= '0;
               end
            end
            StData: begin
               if (bit_end) begin
                  if (last_data) begin
                     bit_q <= '0;
                     if (par_en_q) begin
                        state_q <= StParity;
                        tx_q    <= par_bit_q;
                     end else begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
            end
            StParity: begin
               if (bit_end) begin
                  state_q <= StStop;
                  tx_q    <= 1'b1;
                  bit_q   <= '0;
               end
            end
            StStop: begin
               if (bit_end) begin
                  if (last_stop) begin
                     done_q <= 1'b1;
                     bit_q  <= '0;
                     if (fifo_pop) begin
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                     end else begin
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign tx       = tx_q;
   assign tx_done  = done_q;
   assign busy     = (state_q != StIdle);
   assign tx_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: 8-bit and 5-bit instances, a per-cycle serial frame
// monitor fed by a scoreboard of expected frames, and scenario tasks.
module tb_uart_tx_ext;

   localparam int OS = 16;

   typedef struct packed {
      logic [15:0] bits;
      int          len;
   } frame_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       b_tick = 1'b0;
   logic [1:0] parity_mode = 2'b00;
   logic       two_stop = 1'b0;

   logic [7:0] d8 = '0;
   logic       valid8 = 1'b0;
   logic       ready8, tx8, done8, busy8;
   logic [2:0] level8;

   logic [4:0] d5 = '0;
   logic       valid5 = 1'b0;
   logic       ready5, tx5, done5, busy5;
   logic [2:0] level5;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   frame_t q8[$];
   frame_t q5[$];

   // Monitor state per channel (0: 8-bit DUT, 1: 5-bit DUT).
   frame_t cur[2];
   int     active[2];
   int     idx[2];
   int     ticks[2];
   int     ftick[2];
   int     bad[2];
   logic   bad_val[2];
   int     pend[2];
   int     last_end[2];
   int     done_cnt[2];
   int     starts[2];
   int     contig[2];
   int     meas_ticks[2];

   uart_tx_ext #(
      .DATA_BITS  (8),
      .OVERSAMPLE (OS),
      .FIFO_DEPTH (4)
   ) dut8 (
      .clk         (clk),
      .reset       (reset),
      .b_tick      (b_tick),
      .d_in        (d8),
      .tx_valid    (valid8),
      .tx_ready    (ready8),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .tx          (tx8),
      .tx_done     (done8),
      .busy        (busy8),
      .fifo_level  (level8)
   );

   uart_tx_ext #(
      .DATA_BITS  (5),
      .OVERSAMPLE (OS),
      .FIFO_DEPTH (4)
   ) dut5 (
      .clk         (clk),
      .reset       (reset),
      .b_tick      (b_tick),
      .d_in        (d5),
      .tx_valid    (valid5),
      .tx_ready    (ready5),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .tx          (tx5),
      .tx_done     (done5),
      .busy        (busy5),
      .fifo_level  (level5)
   );

   always #5 clk = ~clk;

   // Baud ticks arrive irregularly, roughly every other cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         b_tick = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

   function automatic frame_t make_frame(input int nb, input logic [8:0] d,
                                         input logic [1:0] pm, input logic ts);
      frame_t f;
      logic   p;
      int     k;
      f.bits    = '1;
      f.bits[0] = 1'b0;
      p = 1'b0;
      for (int i = 0; i < nb; i++) begin
         f.bits[1 + i] = d[i];
         p = p ^ d[i];
      end
      k = 1 + nb;
      if (pm == 2'b01) begin
         f.bits[k] = p;
         k++;
      end else if (pm == 2'b10) begin
         f.bits[k] = ~p;
         k++;
      end
      k = k + (ts ? 2 : 1);
      f.len = k;
      return f;
   endfunction

   task automatic mon_chan(input int ch, input logic txv, input logic donev);
      if (reset) begin
         active[ch] = 0;
         pend[ch] = 0;
         if (ch == 0) q8.delete();
         else q5.delete();
         return;
      end
      if (donev) begin
         checks++;
         if (pend[ch] == 0) begin
            errors++;
            $display("FAIL tx_done_unexpected ch%0d got 1 want 0 at cycle %0d", ch, cyc);
         end else begin
            meas_ticks[ch] = ftick[ch];
         end
         done_cnt[ch]++;
      end else if (pend[ch] != 0) begin
         checks++;
         errors++;
         $display("FAIL tx_done_missing ch%0d got 0 want 1 at cycle %0d", ch, cyc);
      end
      pend[ch] = 0;
      if (active[ch] == 0 && txv === 1'b0) begin
         starts[ch]++;
         if (cyc == last_end[ch] + 1) contig[ch]++;
         if ((ch == 0 && q8.size() == 0) || (ch == 1 && q5.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame ch%0d got start want idle at cycle %0d", ch, cyc);
            cur[ch].bits = '0;
            cur[ch].len  = 1;
         end else if (ch == 0) begin
            cur[ch] = q8.pop_front();
         end else begin
            cur[ch] = q5.pop_front();
         end
         active[ch] = 1;
         idx[ch]    = 0;
         ticks[ch]  = 0;
         ftick[ch]  = 0;
         bad[ch]    = 0;
      end
      if (active[ch] != 0) begin
         if (txv !== cur[ch].bits[idx[ch]] && bad[ch] == 0) begin
            bad[ch]     = 1;
            bad_val[ch] = txv;
         end
         if (b_tick) begin
            ftick[ch]++;
            ticks[ch]++;
            if (ticks[ch] == OS) begin
               checks++;
               if (bad[ch] != 0) begin
                  errors++;
                  $display("FAIL frame_bit ch%0d bit%0d got %b want %b", ch, idx[ch],
                           bad_val[ch], cur[ch].bits[idx[ch]]);
               end
               ticks[ch] = 0;
               bad[ch]   = 0;
               idx[ch]++;
               if (idx[ch] == cur[ch].len) begin
                  active[ch]   = 0;
                  pend[ch]     = 1;
                  last_end[ch] = cyc;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      mon_chan(0, tx8, done8);
      mon_chan(1, tx5, done5);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int ch, input int target, input int budget);
      int n = 0;
      while (done_cnt[ch] < target && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (done_cnt[ch] != target) begin
         errors++;
         $display("FAIL wait_done ch%0d got %0d want %0d", ch, done_cnt[ch], target);
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks++;
      if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx8); end
      checks++;
      if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
      checks++;
      if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
      checks++;
      if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready8); end
      checks++;
      if (level8 !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level8); end
      reset = 1'b0;
      repeat (2) step();
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got tx=%b busy=%b want tx=1 busy=0", tx8, busy8);
      end
   endtask

   task automatic test_8n1();
      int d0 = done_cnt[0];
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      q8.push_back(make_frame(8, 9'h0A5, 2'b00, 1'b0));
      d8 = 8'hA5;
      valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      checks++;
      if (level8 !== 3'd1 || tx8 !== 1'b1) begin
         errors++;
         $display("FAIL push_n1 got level=%0d tx=%b want level=1 tx=1", level8, tx8);
      end
      step();
      checks++;
      if (tx8 !== 1'b0 || busy8 !== 1'b1 || level8 !== 3'd0) begin
         errors++;
         $display("FAIL push_n2 got tx=%b busy=%b level=%0d want tx=0 busy=1 level=0",
                  tx8, busy8, level8);
      end
      wait_done(0, d0 + 1, 2000);
      checks++;
      if (meas_ticks[0] != 160) begin
         errors++;
         $display("FAIL ticks_8n1 got %0d want 160", meas_ticks[0]);
      end
   endtask

   task automatic test_parity_stop();
      int d0 = done_cnt[0];
      parity_mode = 2'b01;
      two_stop    = 1'b1;
      q8.push_back(make_frame(8, 9'h05A, 2'b01, 1'b1));
      d8 = 8'h5A;
      valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      wait_done(0, d0 + 1, 2000);
      checks++;
      if (meas_ticks[0] != 192) begin
         errors++;
         $display("FAIL ticks_8e2 got %0d want 192", meas_ticks[0]);
      end
      parity_mode = 2'b10;
      two_stop    = 1'b0;
      q8.push_back(make_frame(8, 9'h05A, 2'b10, 1'b0));
      valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      wait_done(0, d0 + 2, 2000);
      checks++;
      if (meas_ticks[0] != 176) begin
         errors++;
         $display("FAIL ticks_8o1 got %0d want 176", meas_ticks[0]);
      end
   endtask

   task automatic test_back_to_back();
      int   d0 = done_cnt[0];
      int   c0 = contig[0];
      logic exp_ready;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_ready = (i < 5);
         checks++;
         if (ready8 !== exp_ready) begin
            errors++;
            $display("FAIL b2b_ready push%0d got %b want %b", i, ready8, exp_ready);
         end
         d8 = 8'h30 + 8'(i);
         valid8 = 1'b1;
         if (i < 5) q8.push_back(make_frame(8, {1'b0, d8}, 2'b00, 1'b0));
         step();
      end
      valid8 = 1'b0;
      wait_done(0, d0 + 5, 6000);
      checks++;
      if (contig[0] - c0 != 4) begin
         errors++;
         $display("FAIL b2b_contiguous got %0d want 4", contig[0] - c0);
      end
   endtask

   task automatic test_parity_change();
      int d0 = done_cnt[0];
      parity_mode = 2'b01;
      two_stop    = 1'b0;
      q8.push_back(make_frame(8, 9'h037, 2'b01, 1'b0));
      d8 = 8'h37;
      valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      repeat (100) step();
      checks++;
      if (busy8 !== 1'b1) begin errors++; $display("FAIL pchg_busy got %b want 1", busy8); end
      parity_mode = 2'b10;
      q8.push_back(make_frame(8, 9'h037, 2'b10, 1'b0));
      valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      wait_done(0, d0 + 2, 3000);
   endtask

   task automatic test_reset_mid();
      int d0;
      int s0;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d8 = 8'hC0 + 8'(i);
         valid8 = 1'b1;
         q8.push_back(make_frame(8, {1'b0, d8}, 2'b00, 1'b0));
         step();
      end
      valid8 = 1'b0;
      repeat (80) step();
      checks++;
      if (level8 !== 3'd2 || busy8 !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre got level=%0d busy=%b want level=2 busy=1", level8, busy8);
      end
      reset = 1'b1;
      step();
      checks++;
      if (tx8 !== 1'b1 || level8 !== 3'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL rmid_post got tx=%b level=%0d busy=%b done=%b want 1 0 0 0",
                  tx8, level8, busy8, done8);
      end
      reset = 1'b0;
      d0 = done_cnt[0];
      s0 = starts[0];
      repeat (1500) step();
      checks++;
      if (done_cnt[0] != d0 || starts[0] != s0 || tx8 !== 1'b1) begin
         errors++;
         $display("FAIL rmid_quiet got done=%0d starts=%0d tx=%b want done=%0d starts=%0d tx=1",
                  done_cnt[0], starts[0], tx8, d0, s0);
      end
   endtask

   task automatic test_five_bits();
      int d0 = done_cnt[1];
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      q5.push_back(make_frame(5, 9'h013, 2'b00, 1'b0));
      d5 = 5'h13;
      valid5 = 1'b1;
      step();
      valid5 = 1'b0;
      wait_done(1, d0 + 1, 1500);
      checks++;
      if (meas_ticks[1] != 112) begin
         errors++;
         $display("FAIL ticks_5n1 got %0d want 112", meas_ticks[1]);
      end
   endtask

   initial begin
      for (int c = 0; c < 2; c++) begin
         active[c] = 0; idx[c] = 0; ticks[c] = 0; ftick[c] = 0; bad[c] = 0;
         bad_val[c] = 1'b0; pend[c] = 0; last_end[c] = -10; done_cnt[c] = 0;
         starts[c] = 0; contig[c] = 0; meas_ticks[c] = 0;
         cur[c] = '0;
      end
      test_reset();
      test_8n1();
      test_parity_stop();
      test_back_to_back();
      test_parity_change();
      test_reset_mid();
      test_five_bits();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
